// File: rtl/mux_sel_scanner.sv
// ---------------------------------------------------------------------------
// mux_sel_scanner
//
// Drives the 2-bit channel select of the downstream 4:1 data mux. In auto
// mode sel steps through the enabled channels on a dwell timer. In manual
// mode sel steps one channel per debounced push-button press. Disabled
// channels are always skipped.
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  synchronous active-low reset
//   auto_en     in   1  1 = auto scan, 0 = manual step (synchronous level)
//   btn_step    in   1  raw push button, active-high, asynchronous, bouncing
//   ch_mask     in   4  bit i = 1 enables channel i (synchronous)
//   sel         out  2  channel select to the mux
//   sel_valid   out  1  sel addresses an enabled channel
//   step_pulse  out  1  one-cycle strobe in the cycle sel takes a new value
// ---------------------------------------------------------------------------
module mux_sel_scanner #(
    parameter int DWELL_CYCLES = 50_000_000,  // cycles per channel in auto mode (>=2)
    parameter int DB_CYCLES    = 1_000_000    // button stable time before acceptance (>=2)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       auto_en,
    input  logic       btn_step,
    input  logic [3:0] ch_mask,
    output logic [1:0] sel,
    output logic       sel_valid,
    output logic       step_pulse
);

    localparam int DW_W = $clog2(DWELL_CYCLES);
    localparam int DB_W = $clog2(DB_CYCLES);

    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AUTO,
        S_MANUAL
    } state_t;

    state_t            state;
    logic              sync_1;
    logic              sync_2;
    logic              db_level;
    logic [DB_W-1:0]   db_cnt;
    logic              press_evt;
    logic [DW_W-1:0]   dwell_cnt;
    logic [1:0]        sel_next;
    logic [1:0]        sel_low;

    // -----------------------------------------------------------------------
    // First enabled channel in the order c+1, c+2, c+3, c (mod 4). With an
    // empty mask the current channel is returned unchanged.
    // -----------------------------------------------------------------------
    function automatic logic [1:0] next_ch(input logic [1:0] cur, input logic [3:0] mask);
        logic [1:0] cand;
        logic       found;
        next_ch = cur;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = cur + 2'(i);
            if (!found && mask[cand]) begin
                next_ch = cand;
                found   = 1'b1;
            end
        end
    endfunction

    // Lowest enabled index; only consulted when the mask is non-zero.
    function automatic logic [1:0] lowest_ch(input logic [3:0] mask);
        if (mask[0])      lowest_ch = 2'd0;
        else if (mask[1]) lowest_ch = 2'd1;
        else if (mask[2]) lowest_ch = 2'd2;
        else              lowest_ch = 2'd3;
    endfunction

    // NOTE: every variable an always_comb writes gets a value on every path
    // (here unconditionally), otherwise synthesis infers a latch.
    always_comb begin
        sel_next = next_ch(sel, ch_mask);
        sel_low  = lowest_ch(ch_mask);
    end

    // -----------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous button.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so sync_2 picks up
    // the old sync_1, giving a true two-stage shift rather than a wire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn_step;
            sync_2 <= sync_1;
        end
    end

    // -----------------------------------------------------------------------
    // Debouncer. The counter runs while the synchronised button disagrees
    // with the accepted level and restarts whenever they agree, so only
    // DB_CYCLES consecutive disagreeing cycles flip the level. A 0->1 flip
    // produces a registered one-cycle press event.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_level  <= 1'b0;
            db_cnt    <= '0;
            press_evt <= 1'b0;
        end else begin
            press_evt <= 1'b0;
            if (sync_2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt    <= '0;
                db_level  <= sync_2;
                press_evt <= sync_2;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Scan FSM with registered outputs.
    //
    // Per-cycle priority in AUTO/MANUAL:
    //   1. mask repair  - sel points at a disabled channel
    //   2. dwell expiry (AUTO) or press event (MANUAL)
    // Only one step is taken per cycle. step_pulse follows an actual change
    // of sel, so a lone enabled channel advances onto itself silently.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the counters are ordinary flops and are cleared here;
            // the only storage kept out of reset would be a RAM, and there is none.
            state      <= S_IDLE;
            sel        <= 2'd0;
            sel_valid  <= 1'b0;
            step_pulse <= 1'b0;
            dwell_cnt  <= '0;
        end else begin
            step_pulse <= 1'b0;

            if (ch_mask == 4'b0000) begin
                // Nothing to address: park in IDLE and hold sel.
                state     <= S_IDLE;
                sel_valid <= 1'b0;
                dwell_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // Initial load is not a step, so no pulse.
                        sel       <= sel_low;
                        sel_valid <= 1'b1;
                        dwell_cnt <= '0;
                        state     <= auto_en ? S_AUTO : S_MANUAL;
                    end

                    S_AUTO, S_MANUAL: begin
                        sel_valid <= 1'b1;

                        if (!ch_mask[sel]) begin
                            sel        <= sel_next;
                            step_pulse <= (sel_next != sel);
                            dwell_cnt  <= '0;
                        end else if (state == S_AUTO) begin
                            // Press events are ignored while scanning.
                            if (dwell_cnt == DW_LAST) begin
                                sel        <= sel_next;
                                step_pulse <= (sel_next != sel);
                                dwell_cnt  <= '0;
                            end else begin
                                dwell_cnt <= dwell_cnt + DW_W'(1);
                            end
                        end else begin
                            dwell_cnt <= '0;
                            if (press_evt) begin
                                sel        <= sel_next;
                                step_pulse <= (sel_next != sel);
                            end
                        end

                        // Leaving AUTO parks the timer at 0; entering AUTO
                        // from MANUAL finds it already at 0, so a full dwell
                        // always follows a mode change into AUTO.
                        if (!auto_en) begin
                            dwell_cnt <= '0;
                        end
                        state <= auto_en ? S_AUTO : S_MANUAL;
                    end

                    default: begin
                        state     <= S_IDLE;
                        sel_valid <= 1'b0;
                        dwell_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mux_sel_scanner.sv
// ---------------------------------------------------------------------------
// tb_mux_sel_scanner
//
// Directed bench for mux_sel_scanner with DWELL_CYCLES=4, DB_CYCLES=3.
// Each expected new sel value is queued when the stimulus that causes it is
// applied; a monitor pops one entry for every step_pulse and compares sel.
// Cycle-level checks of pulse timing, sel and sel_valid run inline.
// ---------------------------------------------------------------------------
module tb_mux_sel_scanner;

    logic       clk;
    logic       rst_n;
    logic       auto_en;
    logic       btn_step;
    logic [3:0] ch_mask;
    logic [1:0] sel;
    logic       sel_valid;
    logic       step_pulse;

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_q[$];
    int         n_pulse;

    mux_sel_scanner #(
        .DWELL_CYCLES(4),
        .DB_CYCLES   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .auto_en   (auto_en),
        .btn_step  (btn_step),
        .ch_mask   (ch_mask),
        .sel       (sel),
        .sel_valid (sel_valid),
        .step_pulse(step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_sel",   sel,        2'd0);
        check("rst_valid", sel_valid,  1'b0);
        check("rst_pulse", step_pulse, 1'b0);
        rst_n = 1'b1;
    endtask

    // Scoreboard side: every pulse must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (step_pulse === 1'b1) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_pulse observed sel=%0d expected no pulse", sel);
            end
            if (exp_q.size() != 0) begin
                check("pulse_sel", sel, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        auto_en  = 1'b1;
        btn_step = 1'b0;
        ch_mask  = 4'b1111;

        // ---- 1: auto scan over all four channels --------------------------
        do_reset();
        tick();
        check("t1_load_valid", sel_valid,  1'b1);
        check("t1_load_sel",   sel,        2'd0);
        check("t1_load_pulse", step_pulse, 1'b0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("t1_pulse_time", step_pulse, (k % 4) == 0);
        end
        check("t1_end_sel", sel, 2'd0);

        // ---- 2: mask 1010 repairs to 1 then scans 1,3,1,3 ----------------
        ch_mask = 4'b1010;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        for (int k = 1; k <= 13; k++) begin
            tick();
            check("t2_pulse_time", step_pulse, (k % 4) == 1);
        end
        ch_mask = 4'b0000;
        tick();
        check("t2_empty_valid", sel_valid,  1'b0);
        check("t2_empty_pulse", step_pulse, 1'b0);
        ch_mask = 4'b0100;
        tick();
        check("t2_reload_sel",   sel,        2'd2);
        check("t2_reload_valid", sel_valid,  1'b1);
        check("t2_reload_pulse", step_pulse, 1'b0);

        // ---- 3: manual, bouncing button gives exactly one step ------------
        auto_en = 1'b0;
        ch_mask = 4'b1111;
        do_reset();
        tick();
        check("t3_load_sel", sel, 2'd0);
        for (int k = 0; k < 4; k++) begin
            btn_step = (k % 2) == 0;
            tick();
            check("t3_bounce_nopulse", step_pulse, 1'b0);
        end
        exp_q.push_back(2'd1);
        btn_step = 1'b1;
        n_pulse  = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_pulse += int'(step_pulse);
            check("t3_press1_time", step_pulse, k == 6);
        end
        check("t3_press1_count", n_pulse, 1);
        check("t3_press1_sel",   sel,     2'd1);
        btn_step = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t3_release_nopulse", step_pulse, 1'b0);
        end
        exp_q.push_back(2'd2);
        btn_step = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t3_press2_time", step_pulse, k == 6);
        end
        check("t3_press2_sel", sel, 2'd2);

        // ---- 4: mask repair wins over a same-edge press -------------------
        btn_step = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        exp_q.push_back(2'd3);
        btn_step = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 5) ch_mask = 4'b1011;
            check("t4_pulse_time", step_pulse, k == 6);
        end
        check("t4_sel", sel, 2'd3);

        // ---- 5: single enabled channel never pulses -----------------------
        btn_step = 1'b0;
        auto_en  = 1'b1;
        ch_mask  = 4'b0001;
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            tick();
            check("t5_sel",     sel,        2'd0);
            check("t5_nopulse", step_pulse, 1'b0);
        end
        check("t5_valid", sel_valid, 1'b1);

        // ---- 6: reset mid-dwell, then full dwell from 0 -------------------
        ch_mask = 4'b1111;
        do_reset();
        tick();
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        for (int k = 1; k <= 14; k++) begin
            tick();
            check("t6_pulse_time", step_pulse, (k % 4) == 0);
        end
        check("t6_pre_sel", sel, 2'd3);
        rst_n = 1'b0;
        tick();
        check("t6_rst_sel",   sel,        2'd0);
        check("t6_rst_valid", sel_valid,  1'b0);
        check("t6_rst_pulse", step_pulse, 1'b0);
        rst_n = 1'b1;
        tick();
        check("t6_reload_sel",   sel,       2'd0);
        check("t6_reload_valid", sel_valid, 1'b1);
        exp_q.push_back(2'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t6_full_dwell", step_pulse, k == 4);
        end
        check("t6_after_sel", sel, 2'd1);

        tick();
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
